// File: rtl/cordic_phase_gen_if.sv
// Control and sample-stream bundle between a run controller (master) and
// cordic_phase_gen (slave).
interface cordic_phase_gen_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             stop;
    logic             sweep_en;
    logic [31:0]      phase_off;
    logic [31:0]      fcw_start;
    logic [31:0]      fcw_step;
    logic [CNT_W-1:0] sweep_len;

    logic [31:0]      angle;
    logic [15:0]      Xin;
    logic [15:0]      Yin;
    logic             busy;
    logic             out_valid;
    logic             done;

    modport master (
        output start, stop, sweep_en, phase_off, fcw_start, fcw_step, sweep_len,
        input  angle, Xin, Yin, busy, out_valid, done
    );

    modport slave (
        input  start, stop, sweep_en, phase_off, fcw_start, fcw_step, sweep_len,
        output angle, Xin, Yin, busy, out_valid, done
    );
endinterface

// File: rtl/cordic_phase_gen.sv
// Phase-accumulator angle source for the pipelined CORDIC rotator: fixed tone or
// linear sweep, with the issue strobe delayed by the rotator latency.
module cordic_phase_gen #(
    parameter int          LATENCY = 32,
    parameter logic [15:0] AMP     = 16'd19898,
    parameter int          CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    cordic_phase_gen_if.slave bus
);
    localparam int WAIT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t             state_q, state_d;
    logic [31:0]        angle_q;
    logic [31:0]        fcw_q;
    logic [31:0]        step_q;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sweep_q;
    logic [WAIT_W-1:0]  wcnt_q;
    logic [LATENCY-1:0] dline_q;
    logic [15:0]        xin_q;
    logic               busy_q;
    logic               done_q;
    logic               last_sample;

    assign last_sample = sweep_q && (cnt_q == len_q - CNT_W'(1));

    // NOTE: state is updated with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: state_d is defaulted before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                // A zero-length sweep issues nothing and goes straight to draining.
                if (bus.start)
                    state_d = (bus.sweep_en && bus.sweep_len == '0) ? S_DRAIN : S_RUN;
            end
            S_RUN: begin
                if (bus.stop || last_sample) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (wcnt_q == WAIT_W'(LATENCY)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the delay line is an ordinary shift register, so it is reset with the
    // rest of the datapath; a mid-run reset must flush samples still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            angle_q <= '0;
            fcw_q   <= '0;
            step_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            sweep_q <= 1'b0;
            wcnt_q  <= '0;
            dline_q <= '0;
            xin_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        angle_q <= bus.phase_off;
                        fcw_q   <= bus.fcw_start;
                        step_q  <= bus.fcw_step;
                        len_q   <= bus.sweep_len;
                        sweep_q <= bus.sweep_en;
                        cnt_q   <= '0;
                        wcnt_q  <= '0;
                    end
                end
                S_RUN: begin
                    // The exit edge leaves angle on the last issued sample.
                    if (state_d == S_RUN) begin
                        angle_q <= angle_q + fcw_q;
                        if (sweep_q) fcw_q <= fcw_q + step_q;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else begin
                        wcnt_q <= '0;
                    end
                end
                S_DRAIN: wcnt_q <= wcnt_q + WAIT_W'(1);
                default: ;
            endcase

            dline_q <= LATENCY'({dline_q, state_q == S_RUN});
            xin_q   <= (state_d == S_RUN) ? AMP : 16'd0;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_q == S_DRAIN) && (wcnt_q == WAIT_W'(LATENCY - 1));
        end
    end

    assign bus.angle     = angle_q;
    assign bus.Xin       = xin_q;
    assign bus.Yin       = 16'd0;
    assign bus.busy      = busy_q;
    assign bus.out_valid = dline_q[LATENCY-1];
    assign bus.done      = done_q;
endmodule

// File: tb/tb_cordic_phase_gen.sv
// Self-checking bench for cordic_phase_gen: directed and randomised tone/sweep
// runs compared cycle by cycle against a closed-form model.
module tb_cordic_phase_gen;
    localparam int          LATENCY = 32;
    localparam logic [15:0] AMP     = 16'd19898;
    localparam int          CNT_W   = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    cordic_phase_gen_if #(.CNT_W(CNT_W)) bus ();

    cordic_phase_gen #(.LATENCY(LATENCY), .AMP(AMP), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // angle_k = phase_off + k*fcw_start + k(k-1)/2 * fcw_step, all mod 2^32
    function automatic logic [31:0] angle_at(input int k, input logic [31:0] po,
                                             input logic [31:0] fs, input logic [31:0] st,
                                             input bit sweep);
        logic [31:0] kk;
        logic [31:0] tri_k;
        kk    = 32'(k);
        tri_k = sweep ? 32'((k * (k - 1)) / 2) : 32'd0;
        return po + kk * fs + tri_k * st;
    endfunction

    task automatic clear_inputs();
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.sweep_en  = 1'b0;
        bus.phase_off = '0;
        bus.fcw_start = '0;
        bus.fcw_step  = '0;
        bus.sweep_len = '0;
    endtask

    // Called on a negedge with the DUT idle. stop_at is the cycle index (0 = first
    // cycle after the start edge) during which stop is held; -1 means never.
    task automatic run(input string name, input bit sweep, input logic [31:0] po,
                       input logic [31:0] fs, input logic [31:0] st, input int len,
                       input int stop_at, input bit start_in_run, input bit stop_in_drain);
        int n;
        int ov_seen;
        int done_seen;
        logic [31:0] exp_angle;
        if (sweep) n = (stop_at >= 0 && stop_at + 1 < len) ? stop_at + 1 : len;
        else       n = stop_at + 1;
        ov_seen   = 0;
        done_seen = 0;

        bus.start     = 1'b1;
        bus.sweep_en  = sweep;
        bus.phase_off = po;
        bus.fcw_start = fs;
        bus.fcw_step  = st;
        bus.sweep_len = CNT_W'(len);
        @(negedge clk);
        // Scramble the sampled-with-start inputs to show they were latched.
        bus.start     = 1'b0;
        bus.sweep_en  = ~sweep;
        bus.phase_off = $urandom;
        bus.fcw_start = $urandom;
        bus.fcw_step  = $urandom;
        bus.sweep_len = CNT_W'($urandom);

        for (int c = 0; c <= n + LATENCY + 2; c++) begin
            if (c < n)      exp_angle = angle_at(c, po, fs, st, sweep);
            else if (n > 0) exp_angle = angle_at(n - 1, po, fs, st, sweep);
            else            exp_angle = po;
            check({name, ":angle"}, bus.angle, exp_angle);
            check({name, ":xin"}, 32'(bus.Xin), (c < n) ? 32'(AMP) : 32'd0);
            check({name, ":yin"}, 32'(bus.Yin), 32'd0);
            check({name, ":busy"}, 32'(bus.busy), 32'(c <= n + LATENCY));
            check({name, ":out_valid"}, 32'(bus.out_valid),
                  32'(c >= LATENCY && c - LATENCY < n));
            check({name, ":done"}, 32'(bus.done), 32'(c == n + LATENCY));
            ov_seen   += int'(bus.out_valid);
            done_seen += int'(bus.done);

            bus.stop  = (c == stop_at) || (stop_in_drain && c == n + 2);
            bus.start = start_in_run && (c == 2);
            @(negedge clk);
            bus.stop  = 1'b0;
            bus.start = 1'b0;
        end
        check({name, ":valid_count"}, 32'(ov_seen), 32'(n));
        check({name, ":done_count"}, 32'(done_seen), 32'd1);
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            check("idle:angle", bus.angle, 32'd0);
            check("idle:xin", 32'(bus.Xin), 32'd0);
            check("idle:busy", 32'(bus.busy), 32'd0);
            check("idle:out_valid", 32'(bus.out_valid), 32'd0);
            check("idle:done", 32'(bus.done), 32'd0);
            // stop alone in IDLE must not start anything
            bus.stop = (i == 4);
            @(negedge clk);
        end
        bus.stop = 1'b0;

        run("tone_wrap", 1'b0, 32'h0, 32'h4000_0000, 32'h0, 0, 7, 1'b1, 1'b1);
        run("sweep4", 1'b1, 32'h1000, 32'h100, 32'h10, 4, -1, 1'b1, 1'b1);
        run("sweep4_stop_last", 1'b1, 32'h1000, 32'h100, 32'h10, 4, 3, 1'b0, 1'b0);
        run("sweep_len0", 1'b1, 32'h55AA_0000, 32'h100, 32'hFFFF_FFF0, 0, -1, 1'b0, 1'b1);
        run("sweep_early_stop", 1'b1, 32'hFFFF_FF00, 32'h8000_0000, 32'hFFFF_FFF0, 9, 2,
            1'b0, 1'b0);

        // start and stop together in IDLE: start wins
        bus.stop = 1'b1;
        run("start_stop_idle", 1'b0, 32'h1234_5678, 32'h0101_0101, 32'h0, 0, 1, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            bit is_sweep;
            is_sweep = r[0];
            run($sformatf("rand%0d", r), is_sweep, $urandom, $urandom, $urandom,
                int'($urandom_range(1, 7)), is_sweep ? int'($urandom_range(0, 9)) - 3
                                                     : int'($urandom_range(0, 9)),
                1'b1, 1'b1);
        end

        // Reset mid-run with samples in flight.
        bus.start     = 1'b1;
        bus.fcw_start = 32'h0123_4567;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_pre:busy", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst:angle", bus.angle, 32'd0);
        check("rst:xin", 32'(bus.Xin), 32'd0);
        check("rst:busy", 32'(bus.busy), 32'd0);
        check("rst:out_valid", 32'(bus.out_valid), 32'd0);
        check("rst:done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < LATENCY + 5; c++) begin
            check("post_rst:out_valid", 32'(bus.out_valid), 32'd0);
            check("post_rst:done", 32'(bus.done), 32'd0);
            check("post_rst:busy", 32'(bus.busy), 32'd0);
            @(negedge clk);
        end
        clear_inputs();

        run("after_rst", 1'b1, 32'hDEAD_0000, 32'h10, 32'h1, 3, -1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cordic_phase_gen.md
Name: cordic_phase_gen

Overview:
Upstream stimulus stage for the 16-bit pipelined CORDIC rotator. Generates the 32-bit binary-angle stream (2^32 = 360°, bits [31:30] = quadrant) from a phase accumulator in fixed-tone or linear-sweep mode. Drives constant gain-compensated Xin/Yin. Delays its issue strobe by the rotator latency so out_valid marks valid COS_OUT/SIN_OUT samples.

Parameters:
LATENCY, 32, rotator pipeline depth in clk cycles from angle/Xin/Yin sample to valid COS_OUT/SIN_OUT; must be ≥1.
AMP, 16'd19898, Xin value (≈0.6073·32767, pre-cancels CORDIC gain).
CNT_W, 16, width of the sweep sample counter.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a run; honoured only in IDLE
stop  in  1  one-cycle request to end a run; honoured only in RUN
sweep_en  in  1  0 = fixed tone, 1 = linear sweep; sampled with start
phase_off  in  32  initial phase; sampled with start
fcw_start  in  32  initial frequency control word (phase increment); sampled with start
fcw_step  in  32  per-sample FCW increment, two's complement; sampled with start
sweep_len  in  CNT_W  sweep sample count; sampled with start
angle  out  32  phase to rotator
Xin  out  16  AMP while issuing, else 0
Yin  out  16  always 0
busy  out  1  high in RUN and DRAIN
out_valid  out  1  rotator output valid, issue strobe delayed LATENCY cycles
done  out  1  one-cycle pulse at end of DRAIN

Behaviour:
- Reset (async assert, sync release): state IDLE. angle=0, Xin=0, Yin=0, busy=0, out_valid=0, done=0. FCW, counter and the whole delay line cleared.
- States: IDLE, RUN, DRAIN. Internal issue strobe iss=1 only in RUN.
- IDLE: start=1 → next cycle RUN. Latch sweep_en, fcw_step, sweep_len. Set angle=phase_off and fcw=fcw_start. iss=1 on that first RUN cycle.
- RUN, each cycle after the first:
  - angle += fcw, mod 2^32; wrap is silent.
  - If sweep mode: fcw += fcw_step, mod 2^32. The new fcw applies from the following sample, so angle_k = angle_{k-1} + fcw_start + (k-1)·fcw_step for k ≥ 1.
  - Sample counter increments per issued sample.
- RUN exit:
  - Sweep mode: after the sample with counter = sweep_len−1 is issued → DRAIN next cycle. Exactly sweep_len samples are issued.
  - stop=1 in any mode → DRAIN next cycle. The sample on the stop cycle is still issued.
  - stop on the same cycle as the last sweep sample: identical result, no extra sample.
- sweep_len=0 in sweep mode → IDLE goes straight to DRAIN. Zero samples issued, done after LATENCY cycles.
- DRAIN: iss=0, Xin=0, angle holds its last value. Wait counter runs LATENCY cycles. done=1 for one cycle on the final DRAIN cycle, then IDLE next cycle.
- busy = (state != IDLE), registered with state.
- out_valid: shift register of depth LATENCY fed by iss. The last out_valid=1 occurs on or before the done cycle; no out_valid after done.
- start in RUN/DRAIN is ignored; stop in IDLE/DRAIN is ignored. start and stop together in IDLE: start wins, stop ignored.
- Reset mid-run: immediate IDLE, delay line flushed, no done pulse.
- Outputs are registered; angle/Xin change only on clk edges.

Test Plan:
- Reset then idle 10 cycles → angle=0, Xin=0, busy=0, out_valid=0, done=0 throughout.
- Tone: phase_off=0, fcw_start=32'h4000_0000, start, stop after 8 samples → angle 0,4000_0000,8000_0000,C000_0000,0,… (wrap checked). out_valid high 8 cycles beginning LATENCY cycles after first sample. done 1 pulse.
- Sweep: phase_off=32'h1000, fcw_start=32'h100, fcw_step=32'h10, sweep_len=4 → angle 1000,1100,1210,1330. Exactly 4 out_valid cycles. done on cycle 4+LATENCY after first sample.
- Negative step with sweep_len=0: fcw_step=32'hFFFF_FFF0, sweep_len=0 → no samples issued, out_valid never high, done exactly LATENCY cycles after DRAIN entry.
- start during RUN and stop during DRAIN → both ignored, angle sequence unchanged. stop on last sweep sample → same count as without stop.
- rst_n asserted mid-RUN (LATENCY=32, 5 samples in flight) → outputs zero asynchronously, out_valid never rises afterwards, no done pulse.
